// File: rtl/irq_pending_latch_if.sv
// Request/acknowledge bundle between the requesting side and the pending latch.
// Latency: none (wires only).
// Backpressure: none; ack is a one-cycle strobe, and its errors come back on ack_err.
//
// Signals: req, mask, ack and ack_idx go into the latch. pend_out, irq, pend_cnt
// and ack_err come out of it. With IRQ_OVERFLOW_EN, ovf_clr goes in and ovf comes out.
interface irq_pending_latch_if #(
    parameter int N  = 8,
    parameter int IW = 3
);
    logic [N-1:0]  req;
    logic [N-1:0]  mask;
    logic          ack;
    logic [IW-1:0] ack_idx;
    logic [N-1:0]  pend_out;
    logic          irq;
    logic [IW:0]   pend_cnt;
    logic          ack_err;
`ifdef IRQ_OVERFLOW_EN
    logic          ovf_clr;
    logic [N-1:0]  ovf;
`endif

    // master: the side that raises requests and acknowledges them.
    modport master (
        output req, mask, ack, ack_idx,
`ifdef IRQ_OVERFLOW_EN
        output ovf_clr,
        input  ovf,
`endif
        input  pend_out, irq, pend_cnt, ack_err
    );

    // slave: the pending latch itself.
    modport slave (
        input  req, mask, ack, ack_idx,
`ifdef IRQ_OVERFLOW_EN
        input  ovf_clr,
        output ovf,
`endif
        output pend_out, irq, pend_cnt, ack_err
    );
endinterface

// File: rtl/irq_pending_latch.sv
// Latches rising edges on request lines as pending bits, masks them and clears them on ack.
// Latency: a rise sampled at edge k shows on pend_out after edge k. An ack at edge j clears its bit after edge j.
// Backpressure: none. An ack that names a bit not visible in pend_out is dropped and pulses ack_err.
//
// Ports: clk and rst (synchronous, active-high) are plain ports. All other signals
// travel on bus (irq_pending_latch_if.slave).
// Optional: define IRQ_OVERFLOW_EN to add ovf_clr and a sticky per-line ovf vector.
module irq_pending_latch #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_pending_latch_if.slave   bus
);
    logic [N-1:0] req_q;
    logic [N-1:0] pending_q, pending_d;
    logic         ack_err_q, ack_err_d;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] pend_vis;
    logic         idx_ok;
    logic         idx_vis;
    logic [IW:0]  cnt;

    assign rise     = bus.req & ~req_q;
    assign pend_vis = pending_q & ~bus.mask;

    // Use one extra bit so that an index of N or above is caught when N is not a power of two.
    assign idx_ok  = ({1'b0, bus.ack_idx} < (IW+1)'(N));
    assign idx_vis = idx_ok && pend_vis[bus.ack_idx];

    // An ack clears only a bit that is currently visible. A masked-but-pending bit stays set.
    always_comb begin
        clr = '0;
        if (bus.ack && idx_vis)
            clr[bus.ack_idx] = 1'b1;
    end

    // A rise wins over a clear on the same bit, so the new event is never lost.
    assign pending_d = (pending_q & ~clr) | rise;
    assign ack_err_d = bus.ack & ~idx_vis;

    always_ff @(posedge clk) begin
        // req_q tracks req even during reset, so a line held high at release raises no event.
        req_q <= bus.req;
        if (rst) begin
            pending_q <= '0;
            ack_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++)
            cnt = cnt + (IW+1)'(pend_vis[i]);
    end

    assign bus.pend_out = pend_vis;
    assign bus.irq      = |pend_vis;
    assign bus.pend_cnt = cnt;
    assign bus.ack_err  = ack_err_q;

`ifdef IRQ_OVERFLOW_EN
    logic [N-1:0] ovf_q, ovf_d;

    // A lost event is a rise on a bit that is already pending and not being cleared in the same cycle.
    // A new loss wins over ovf_clr.
    assign ovf_d = (ovf_q & ~{N{bus.ovf_clr}}) | (rise & pending_q & ~clr);

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= '0;
        else
            ovf_q <= ovf_d;
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;
    localparam int N  = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    irq_pending_latch_if #(.N(N), .IW(IW)) bus ();

    irq_pending_latch #(.N(N), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = 8'hFF;
        bus.mask    = 8'h00;
        bus.ack     = 1'b0;
        bus.ack_idx = 3'd0;
`ifdef IRQ_OVERFLOW_EN
        bus.ovf_clr = 1'b0;
`endif
        #2;
        tick();
        tick();
        check("rst_pend", bus.pend_out, 8'h00);
        check("rst_irq",  bus.irq, 1'b0);
        check("rst_cnt",  bus.pend_cnt, 4'd0);
        check("rst_err",  bus.ack_err, 1'b0);
`ifdef IRQ_OVERFLOW_EN
        check("rst_ovf",  bus.ovf, 8'h00);
`endif
        // Reset is released while req is still held high. No event may be raised.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_pend", bus.pend_out, 8'h00);
            check("held_cnt",  bus.pend_cnt, 4'd0);
        end
        check("held_irq", bus.irq, 1'b0);

        // Two simultaneous rises, then ack each bit in turn.
        bus.req = 8'h00; tick();
        bus.req = 8'h81; tick();
        check("rise81_pend", bus.pend_out, 8'h81);
        check("rise81_irq",  bus.irq, 1'b1);
        check("rise81_cnt",  bus.pend_cnt, 4'd2);
        bus.req = 8'h00; bus.ack = 1'b1; bus.ack_idx = 3'd7; tick();
        check("ack7_pend", bus.pend_out, 8'h01);
        check("ack7_cnt",  bus.pend_cnt, 4'd1);
        check("ack7_err",  bus.ack_err, 1'b0);
        bus.ack_idx = 3'd0; tick();
        check("ack0_pend", bus.pend_out, 8'h00);
        check("ack0_irq",  bus.irq, 1'b0);
        bus.ack = 1'b0; tick();

        // A masked pending bit is hidden. It cannot be acked and it is retained.
        bus.req = 8'h10; tick();
        bus.req = 8'h00; bus.mask = 8'h10; #1;
        check("mask_pend", bus.pend_out, 8'h00);
        check("mask_irq",  bus.irq, 1'b0);
        bus.ack = 1'b1; bus.ack_idx = 3'd4; tick();
        check("maskack_err",  bus.ack_err, 1'b1);
        check("maskack_pend", bus.pend_out, 8'h00);
        bus.ack = 1'b0; tick();
        check("maskack_err_gone", bus.ack_err, 1'b0);
        bus.mask = 8'h00; #1;
        check("unmask_pend", bus.pend_out, 8'h10);
        check("unmask_cnt",  bus.pend_cnt, 4'd1);
        bus.ack = 1'b1; bus.ack_idx = 3'd4; tick();
        bus.ack = 1'b0;
        check("ack4_pend", bus.pend_out, 8'h00);

        // A rise and an ack on the same bit in the same cycle: the set wins.
        bus.req = 8'h04; tick();
        check("set2_pend", bus.pend_out, 8'h04);
        bus.req = 8'h00; tick();
        bus.req = 8'h04; bus.ack = 1'b1; bus.ack_idx = 3'd2; tick();
        check("setwin_pend", bus.pend_out, 8'h04);
        check("setwin_err",  bus.ack_err, 1'b0);
        bus.req = 8'h00; tick();
        check("clr2_pend", bus.pend_out, 8'h00);
        bus.ack = 1'b0;

        // An ack to an empty line pulses ack_err for one cycle only.
        bus.ack = 1'b1; bus.ack_idx = 3'd5; tick();
        check("emptyack_err",  bus.ack_err, 1'b1);
        check("emptyack_pend", bus.pend_out, 8'h00);
        bus.ack = 1'b0; tick();
        check("emptyack_err_gone", bus.ack_err, 1'b0);

        // Several simultaneous rises, then a reset mid-operation that coincides with an ack.
        bus.req = 8'h6A; tick();
        check("multi_pend", bus.pend_out, 8'h6A);
        check("multi_cnt",  bus.pend_cnt, 4'd4);
        rst = 1'b1; bus.ack = 1'b1; bus.ack_idx = 3'd0; tick();
        rst = 1'b0; bus.ack = 1'b0;
        check("midrst_pend", bus.pend_out, 8'h00);
        check("midrst_err",  bus.ack_err, 1'b0);
        tick();
        check("midrst_held", bus.pend_out, 8'h00);

`ifdef IRQ_OVERFLOW_EN
        // Overflow: a second rise on a line that is still pending.
        bus.req = 8'h00; tick();
        bus.req = 8'h08; tick();
        check("ovf_none", bus.ovf, 8'h00);
        bus.req = 8'h00; tick();
        bus.req = 8'h08; tick();
        check("ovf_set", bus.ovf, 8'h08);
        bus.req = 8'h00; bus.ovf_clr = 1'b1; tick();
        check("ovf_clr", bus.ovf, 8'h00);
        bus.req = 8'h08; tick();
        check("ovf_setwins", bus.ovf, 8'h08);
        bus.ovf_clr = 1'b0; bus.req = 8'h00; tick();
        check("ovf_sticky", bus.ovf, 8'h08);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage of the 8-input priority encoder.
- Detects rising edges on raw request lines and holds each request as a pending bit until it is acknowledged.
- Applies a per-line mask and presents the masked pending vector to the encoder. Bit N-1 is highest priority, matching the encoder's p0 wiring.
- Accepts the encoder's chosen index back as an acknowledge that clears exactly one pending bit.

Parameters:
N, 8, number of request lines; pending vector width.
IW, 3, index width, equal to clog2(N); ack_idx width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  raw request lines, synchronous to clk.
mask  input  N  1 = line masked; hides the line from pend_out but pending state is kept.
ack  input  1  acknowledge strobe; valid for one cycle.
ack_idx  input  IW  bit position in pend_out to clear when ack=1.
pend_out  output  N  pending & ~mask, driven from registers; goes to the encoder inputs.
irq  output  1  OR-reduction of pend_out.
pend_cnt  output  IW+1  population count of pend_out, range 0..N.
ack_err  output  1  registered one-cycle pulse: ack named a bit not visible in pend_out.

Behaviour:
- Reset, while rst=1 at a clock edge:
  - pending <= 0, ack_err <= 0, and ovf <= 0 if the optional feature is built.
  - req_q <= req, so lines already high at reset release do not generate an event.
  - Consequently pend_out=0, irq=0 and pend_cnt=0 in the cycle after reset.
- Edge detection: rise = req & ~req_q; req_q <= req every cycle.
- Clear vector: clr = ack ? onehot(ack_idx) : 0.
- ack_idx >= N is ignored: clr=0 and ack_err pulses.
- Pending update per bit: pending[i] <= (pending[i] & ~clr[i]) | rise[i].
  - If a rise and a clear hit the same bit in the same cycle, set wins, so the new event is never lost.
- Latency:
  - req sampled 0 at edge k-1 and 1 at edge k sets the pending bit at edge k.
  - It is visible on pend_out, irq and pend_cnt in the cycle following edge k.
  - ack at edge j removes the bit from pend_out in the cycle after edge j.
- Mask:
  - Purely combinational over the pending register.
  - Masking never clears a bit.
  - Unmasking immediately exposes a retained pending bit.
  - A masked line still captures edges.
- Pulse handling: a held-high req produces exactly one event. The line must go low for at least one sampled cycle to re-arm.
- ack_err <= ack & (ack_idx >= N | ~pend_out[ack_idx]).
  - Such an ack clears nothing, including a masked-but-pending bit.
  - ack_err is high for exactly the one cycle after the offending edge.
- Multiple simultaneous rises are each latched independently.
- pend_cnt is computed combinationally from pend_out; no extra latency.
- Reset mid-operation discards all pending bits. An ack coinciding with rst is ignored and does not pulse ack_err.

Optional Feature:
- Macro: IRQ_OVERFLOW_EN.
- When defined:
  - Adds input ovf_clr (1) and output ovf (N).
  - ovf[i] is set when rise[i]=1 while pending[i]=1 and clr[i]=0, i.e. an event is lost.
  - ovf is sticky and clears on ovf_clr=1. Set wins over ovf_clr in the same cycle.
  - ovf is visible the cycle after the edge.
- When not defined: no ovf_clr or ovf ports, and repeated events on a pending line merge silently.

Test Plan:
- Reset with req=8'hFF held through reset release, then held high for 5 cycles -> pend_out=8'h00, irq=0, pend_cnt=0 throughout.
- From idle, req=8'h00 then 8'h81 for one cycle, mask=0 -> next cycle pend_out=8'h81, irq=1, pend_cnt=2. Then ack=1, ack_idx=7 -> pend_out=8'h01, pend_cnt=1. Then ack_idx=0 -> pend_out=0, irq=0.
- pending=8'h10 with mask=8'h10 -> pend_out=0, irq=0. Then ack, ack_idx=4 -> ack_err=1 for one cycle and pending is retained. Then mask=0 -> pend_out=8'h10 the same cycle.
- pending bit 2 set; in one cycle drive ack_idx=2 and a fresh rise on req[2] -> pend_out[2] stays 1 and ack_err=0.
- ack=1, ack_idx=5 with pend_out=8'h00 -> ack_err pulses for one cycle, no state change.
- With IRQ_OVERFLOW_EN: pending bit 3 set, second rise on req[3] with no ack -> ovf=8'h08 the next cycle. Then ovf_clr=1 -> ovf=0. Then ovf_clr=1 together with a new overflow on bit 3 -> ovf stays 8'h08.
